instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Front-end fetch stage sitting directly upstream of the memory controller's decoder port. Holds the PC and issues one instruction request at a time over the controller's enable/address/ready handshake. Computes the next PC with static prediction (JAL taken, backward conditional branch taken, else fall-through by 2 or 4 bytes). Buffers fetched instructions in a small queue that the decoder drains.

## Interface
Parameters:
- QUEUE_DEPTH, 4: instruction queue entries; power of two, at least 2.
- RESET_PC, 32'h0: PC loaded on reset.

Ports:
- clk_in, in, 1: the single clock.
- rst_in, in, 1: reset; asynchronous, active-low.
- rdy_in, in, 1: global enable; when low, all state freezes.
- flush, in, 1: pipeline redirect; takes effect only when rdy_in is high.
- flush_pc, in, 32: new PC on flush.
- mem_en, out, 1: request to the controller (drives dec_en).
- mem_addr, out, 32: request address (drives dec_addr).
- mem_rdy, in, 1: response valid for exactly one cycle (dec_rdy).
- mem_data, in, 32: 32-bit instruction; compressed instructions arrive already expanded.
- mem_is_compressed, in, 1: the fetched instruction is 2 bytes in memory.
- inst_valid, out, 1: queue head valid.
- inst_data, out, 32: head instruction.
- inst_pc, out, 32: head PC.
- inst_is_compressed, out, 1: head compressed flag.
- inst_pred_taken, out, 1: head was predicted taken.
- inst_ready, in, 1: decoder pops the head when inst_valid && inst_ready && rdy_in.

## Operation
- Registers: pc[31:0], plus a queue of {data, pc, is_compressed, pred_taken} with head/tail pointers and count[log2(QUEUE_DEPTH):0].
- mem_addr = pc. mem_en = (count != QUEUE_DEPTH), and is forced to 0 while rst_in is low.
- mem_en and mem_addr stay stable until mem_rdy. This holds by construction: only a response or a flush changes pc, and only a push can fill the queue.
- On mem_rdy (rdy_in high, no flush):
  - Push {mem_data, pc, mem_is_compressed, pred} into the queue.
  - pc <= next_pc.
- next_pc, using opcode = mem_data[6:0]:
  - 7'b1101111 (JAL): pc + sext J-imm {d[31], d[19:12], d[20], d[30:21], 0}; pred = 1.
  - 7'b1100011 (branch) with d[31] = 1: pc + sext B-imm {d[31], d[7], d[30:25], d[11:8], 0}; pred = 1.
  - Anything else, including JALR and forward branches: pc + (mem_is_compressed ? 2 : 4); pred = 0.
- All adds are 32-bit modulo; wrap-around past 32'hFFFFFFFF is allowed.
- Pop and push in the same cycle: count unchanged, both pointers advance.
- Pop on an empty queue is ignored. A push never occurs when full, because mem_en is low.
- Flush (rdy_in high) overrides everything else in that cycle:
  - pc <= flush_pc.
  - Queue emptied (head = tail = count = 0).
  - Any mem_rdy in the same cycle is discarded and no pop is counted.
  - The controller resets on the same flush, so the new request starts cleanly.
- rdy_in low: no push, pop, pc update or flush. Outputs hold.
- Reset (asynchronous, at any point, including mid-request):
  - pc = RESET_PC, queue empty.
  - inst_valid = 0, inst_data/inst_pc = 0, inst_is_compressed = 0, inst_pred_taken = 0.
  - mem_en = 0, mem_addr = RESET_PC.

## Timing
- Implicit two-state FSM:
  - REQ: count < QUEUE_DEPTH, mem_en = 1.
  - BLOCKED: queue full, mem_en = 0.
  - BLOCKED→REQ in the cycle after a pop. REQ→BLOCKED in the cycle after the push that fills the queue.
- Queue outputs are registered from queue storage. inst_valid rises the cycle after the mem_rdy cycle.
- After mem_rdy at cycle t:
  - mem_addr shows the new pc at t+1.
  - The controller's cooldown absorbs t+1, so the next request is sampled at t+2.
- Throughput on an instruction-cache hit: one instruction per 3 cycles.
- Flush at cycle t: mem_addr = flush_pc and inst_valid = 0 at t+1.

## Structure
- params.v gains OPCODE_JAL = 7'b1101111 and OPCODE_BRANCH = 7'b1100011. Both are shared with the decoder.
- One sub-module, inst_queue:
  - Parameterised synchronous FIFO (width 66, depth QUEUE_DEPTH) with push/pop/clear, full, empty, count.
  - Reset is asynchronous active-low.
- Prediction and next-PC logic stay combinational in instruction_fetch.

## Test plan
- Reset with RESET_PC = 0 → mem_en = 1, mem_addr = 0. Respond mem_rdy with data 32'h00000013, uncompressed → next cycle inst_valid = 1, inst_pc = 0, inst_pred_taken = 0, mem_addr = 4.
- At pc = 4, respond with mem_is_compressed = 1 → next mem_addr = 6; the queue entry has inst_is_compressed = 1.
- At pc = 32'h10, respond with 32'h0100006F (jal x0, +16) → mem_addr = 32'h20, pred_taken = 1. Then respond with 32'hFE000CE3 (beq, −8) → mem_addr = 32'h18, pred_taken = 1.
- QUEUE_DEPTH = 4, inst_ready = 0, four responses → mem_en = 0 and mem_addr held. Pulse inst_ready for one cycle → mem_en = 1 the next cycle, count = 3.
- Request pending with two queued entries; flush = 1, flush_pc = 32'h100, and mem_rdy in the same cycle → inst_valid = 0, the response is dropped, mem_addr = 32'h100.
- Hold rdy_in = 0 while pulsing mem_rdy, inst_ready and flush → no state change. Deassert rst_in mid-request → all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types, opcodes and the static next-PC predictor.
package instruction_fetch_pkg;

  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        is_compressed;
    logic        pred_taken;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  typedef struct packed {
    logic [31:0] next_pc;
    logic        taken;
  } pred_t;

  // JAL and backward conditional branches are predicted taken; all else falls through.
  function automatic pred_t predict(input logic [31:0] pc, input logic [31:0] d,
                                    input logic is_c);
    pred_t       r;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    j_imm = {{11{d[31]}}, d[31], d[19:12], d[20], d[30:21], 1'b0};
    b_imm = {{19{d[31]}}, d[31], d[7], d[30:25], d[11:8], 1'b0};
    r.taken   = 1'b0;
    r.next_pc = pc + (is_c ? 32'd2 : 32'd4);
    if (d[6:0] == OPCODE_JAL) begin
      r.taken   = 1'b1;
      r.next_pc = pc + j_imm;
    end else if (d[6:0] == OPCODE_BRANCH && d[31]) begin
      r.taken   = 1'b1;
      r.next_pc = pc + b_imm;
    end
    return r;
  endfunction

endpackage

// File: rtl/instruction_fetch_inst_queue.sv
// Synchronous FIFO holding fetched instructions until the decoder drains them.
module instruction_fetch_inst_queue
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = ENTRY_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (cnt != CW'(DEPTH));
  assign do_pop  = pop && (cnt != '0);

  // Storage is reset too so the head outputs read zero out of reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= wdata;
        tail      <= tail + AW'(1);
      end
      if (do_pop) head <= head + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata = mem[head];
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one request at a time and queues responses for decode.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [31:0] mem_data,
  input  logic        mem_is_compressed,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_is_compressed,
  output logic        inst_pred_taken,
  input  logic        inst_ready
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]  pc;
  logic [CW-1:0] count;
  logic         empty;
  logic         push;
  logic         pop;
  logic         clear;
  pred_t        pred;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  assign pred  = predict(pc, mem_data, mem_is_compressed);
  assign clear = rdy_in && flush;
  assign push  = rdy_in && !flush && mem_rdy && mem_en;
  assign pop   = rdy_in && !flush && inst_ready && !empty;

  always_comb begin
    wr_entry               = '0;
    wr_entry.data          = mem_data;
    wr_entry.pc            = pc;
    wr_entry.is_compressed = mem_is_compressed;
    wr_entry.pred_taken    = pred.taken;
  end

  // PC only moves on an accepted response or a redirect, keeping the request stable.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc <= RESET_PC;
    end else if (clear) begin
      pc <= flush_pc;
    end else if (push) begin
      pc <= pred.next_pc;
    end
  end

  instruction_fetch_inst_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (push),
    .pop    (pop),
    .clear  (clear),
    .wdata  (wr_entry),
    .rdata  (head),
    .empty  (empty),
    .count  (count)
  );

  // Requesting while the queue has room; held low throughout reset.
  assign mem_en             = rst_in && (count != CW'(QUEUE_DEPTH));
  assign mem_addr           = pc;
  assign inst_valid         = !empty;
  assign inst_data          = head.data;
  assign inst_pc            = head.pc;
  assign inst_is_compressed = head.is_compressed;
  assign inst_pred_taken    = head.pred_taken;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed responses, monitor compares popped entries.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic        mem_rdy = 1'b0;
  logic [31:0] mem_data = '0;
  logic        mem_is_compressed = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_is_compressed;
  logic        inst_pred_taken;
  logic        inst_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  fetch_entry_t exp_q[$];
  logic [31:0] cur_pc;

  instruction_fetch #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .flush              (flush),
    .flush_pc           (flush_pc),
    .mem_en             (mem_en),
    .mem_addr           (mem_addr),
    .mem_rdy            (mem_rdy),
    .mem_data           (mem_data),
    .mem_is_compressed  (mem_is_compressed),
    .inst_valid         (inst_valid),
    .inst_data          (inst_data),
    .inst_pc            (inst_pc),
    .inst_is_compressed (inst_is_compressed),
    .inst_pred_taken    (inst_pred_taken),
    .inst_ready         (inst_ready)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the head against the scoreboard whenever a pop happens.
  always @(negedge clk_in) begin
    if (rst_in && rdy_in) begin
      chk("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
      if (flush) begin
        exp_q.delete();
      end else if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop: got pc %h expected none", inst_pc);
        end else begin
          fetch_entry_t e;
          e = exp_q.pop_front();
          chk("inst_data", inst_data, e.data);
          chk("inst_pc", inst_pc, e.pc);
          chk("inst_is_compressed", 32'(inst_is_compressed), 32'(e.is_compressed));
          chk("inst_pred_taken", 32'(inst_pred_taken), 32'(e.pred_taken));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic respond(input logic [31:0] data, input logic c,
                         input logic [31:0] exp_next, input logic exp_pred);
    fetch_entry_t e;
    int n = 0;
    while (!mem_en && n < 20) begin
      step();
      n++;
    end
    chk("req_en", 32'(mem_en), 32'd1);
    chk("req_addr", mem_addr, cur_pc);
    mem_rdy = 1'b1;
    mem_data = data;
    mem_is_compressed = c;
    step();
    mem_rdy = 1'b0;
    e.data = data;
    e.pc = cur_pc;
    e.is_compressed = c;
    e.pred_taken = exp_pred;
    exp_q.push_back(e);
    chk("valid_after_rsp", 32'(inst_valid), 32'd1);
    chk("next_addr", mem_addr, exp_next);
    cur_pc = exp_next;
    step();
  endtask

  task automatic drain(input int cycles);
    inst_ready = 1'b1;
    repeat (cycles) step();
    inst_ready = 1'b0;
  endtask

  task automatic do_flush(input logic [31:0] addr);
    flush = 1'b1;
    flush_pc = addr;
    step();
    flush = 1'b0;
    chk("flush_addr", mem_addr, addr);
    chk("flush_valid", 32'(inst_valid), 32'd0);
    cur_pc = addr;
  endtask

  initial begin
    cur_pc = 32'h0;
    #2;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_data", inst_data, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    chk("post_rst_en", 32'(mem_en), 32'd1);
    chk("post_rst_addr", mem_addr, 32'h0);
    step();

    respond(32'h00000013, 1'b0, 32'h4, 1'b0);
    chk("head_pc", inst_pc, 32'h0);
    chk("head_pred", 32'(inst_pred_taken), 32'd0);
    respond(32'h00000013, 1'b1, 32'h6, 1'b0);
    drain(3);
    respond(32'h00000463, 1'b0, 32'hA, 1'b0);   // forward beq: fall-through
    respond(32'h00008067, 1'b0, 32'hE, 1'b0);   // jalr: fall-through
    drain(3);

    do_flush(32'h10);
    respond(32'h0100006F, 1'b0, 32'h20, 1'b1);  // jal +16
    respond(32'hFE000CE3, 1'b0, 32'h18, 1'b1);  // beq -8
    respond(32'h00000013, 1'b0, 32'h1C, 1'b0);
    respond(32'h00000013, 1'b0, 32'h20, 1'b0);
    chk("full_en", 32'(mem_en), 32'd0);
    repeat (2) step();
    chk("full_en_hold", 32'(mem_en), 32'd0);
    chk("full_addr_hold", mem_addr, 32'h20);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("unblock_en", 32'(mem_en), 32'd1);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;

    // Flush wins over a coincident response with two entries queued.
    mem_rdy = 1'b1;
    mem_data = 32'h00000013;
    do_flush(32'h100);
    mem_rdy = 1'b0;
    chk("flush_en", 32'(mem_en), 32'd1);
    step();
    chk("flush_drop_valid", 32'(inst_valid), 32'd0);
    chk("flush_drop_addr", mem_addr, 32'h100);

    respond(32'h00000013, 1'b0, 32'h104, 1'b0);
    rdy_in = 1'b0;
    mem_rdy = 1'b1;
    inst_ready = 1'b1;
    flush = 1'b1;
    flush_pc = 32'h200;
    repeat (2) step();
    chk("frz_addr", mem_addr, 32'h104);
    chk("frz_valid", 32'(inst_valid), 32'd1);
    chk("frz_pc", inst_pc, 32'h100);
    chk("frz_en", 32'(mem_en), 32'd1);
    rdy_in = 1'b1;
    mem_rdy = 1'b0;
    inst_ready = 1'b0;
    flush = 1'b0;
    step();
    chk("unfrz_addr", mem_addr, 32'h104);

    do_flush(32'hFFFFFFFC);
    respond(32'h00000013, 1'b0, 32'h0, 1'b0);   // 32-bit wrap
    respond(32'h0100006F, 1'b0, 32'h10, 1'b1);

    // Asynchronous reset between clock edges, with a request outstanding.
    @(posedge clk_in);
    #3;
    rst_in = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_en", 32'(mem_en), 32'd0);
    chk("arst_addr", mem_addr, 32'h0);
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_data", inst_data, 32'h0);
    chk("arst_pc", inst_pc, 32'h0);
    chk("arst_c", 32'(inst_is_compressed), 32'd0);
    chk("arst_pred", 32'(inst_pred_taken), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    step();
    chk("rerun_en", 32'(mem_en), 32'd1);
    chk("rerun_addr", mem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
